regfile_wb_queue: RTL and testbench

Write-back buffer that sits directly upstream of the processor register file and owns its single write port. Accepts up to two results per cycle (load-return path and ALU path), queues them in program order, and drains one entry per cycle into the register file's write port. It also forwards queued-but-unwritten values to the two register-file read ports, so decode sees the architecturally current value.

---
 rtl/regfile_wb_queue_if.sv | 41 ++++
 rtl/regfile_wb_queue.sv | 116 +++++++++++
 tb/tb_regfile_wb_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Bundled ports of the register-file write-back queue: push sources, read-port
// forwarding taps and the register-file write port.
interface regfile_wb_queue_if #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned ABITS = 4
);
    logic             ld_valid;
    logic [ABITS-1:0] ld_addr;
    logic [DBITS-1:0] ld_data;
    logic             alu_valid;
    logic [ABITS-1:0] alu_addr;
    logic [DBITS-1:0] alu_data;
    logic             stall;
    logic [ABITS-1:0] raddr1;
    logic [ABITS-1:0] raddr2;
    logic             fwd1_hit;
    logic             fwd2_hit;
    logic [DBITS-1:0] fwd1_data;
    logic [DBITS-1:0] fwd2_data;
    logic             we;
    logic [ABITS-1:0] waddr;
    logic [DBITS-1:0] din;

    modport master (
        output ld_valid, ld_addr, ld_data,
        output alu_valid, alu_addr, alu_data,
        output raddr1, raddr2,
        input  stall,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        input  we, waddr, din
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        input  alu_valid, alu_addr, alu_data,
        input  raddr1, raddr2,
        output stall,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        output we, waddr, din
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue owning the register-file write port, with read forwarding.
// Optional REGFILE_ZERO_R0_EN: discard pushes to r0 and never forward r0.
module regfile_wb_queue #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned ABITS = 4,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    regfile_wb_queue_if.slave bus_io
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ABITS-1:0] addr_q [DEPTH];
    logic [DBITS-1:0] data_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             stall;
    logic             ld_ok, alu_ok;
    logic             pop;
    logic [1:0]       n_push;
    logic [PW-1:0]    alu_slot;
    logic [PW-1:0]    idx;

    // Stall looks only at registered occupancy so upstream sees a stable signal.
    assign stall = (count_q > CW'(DEPTH - 2));
    assign pop   = (count_q != '0);

`ifdef REGFILE_ZERO_R0_EN
    assign ld_ok  = bus_io.ld_valid  && !stall && (bus_io.ld_addr  != '0);
    assign alu_ok = bus_io.alu_valid && !stall && (bus_io.alu_addr != '0);
`else
    assign ld_ok  = bus_io.ld_valid  && !stall;
    assign alu_ok = bus_io.alu_valid && !stall;
`endif

    assign n_push   = {1'b0, ld_ok} + {1'b0, alu_ok};
    assign alu_slot = ld_ok ? (tail_q + PW'(1)) : tail_q;

    always_comb begin
        head_d  = pop ? (head_q + PW'(1)) : head_q;
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // LD is older than ALU when both arrive in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (ld_ok) begin
                addr_q[tail_q] <= bus_io.ld_addr;
                data_q[tail_q] <= bus_io.ld_data;
            end
            if (alu_ok) begin
                addr_q[alu_slot] <= bus_io.alu_addr;
                data_q[alu_slot] <= bus_io.alu_data;
            end
        end
    end

    assign bus_io.stall = stall;
    assign bus_io.we    = pop;
    assign bus_io.waddr = pop ? addr_q[head_q] : '0;
    assign bus_io.din   = pop ? data_q[head_q] : '0;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        idx              = '0;
        bus_io.fwd1_hit  = 1'b0;
        bus_io.fwd1_data = '0;
        bus_io.fwd2_hit  = 1'b0;
        bus_io.fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (addr_q[idx] == bus_io.raddr1) begin
                    bus_io.fwd1_hit  = 1'b1;
                    bus_io.fwd1_data = data_q[idx];
                end
                if (addr_q[idx] == bus_io.raddr2) begin
                    bus_io.fwd2_hit  = 1'b1;
                    bus_io.fwd2_data = data_q[idx];
                end
            end
        end
`ifdef REGFILE_ZERO_R0_EN
        if (bus_io.raddr1 == '0) begin
            bus_io.fwd1_hit  = 1'b0;
            bus_io.fwd1_data = '0;
        end
        if (bus_io.raddr2 == '0) begin
            bus_io.fwd2_hit  = 1'b0;
            bus_io.fwd2_data = '0;
        end
`endif
    end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue with a simple register-file model on the write port.
module tb_regfile_wb_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [31:0] rf [16] = '{default: 32'h0};

    regfile_wb_queue_if #(.DBITS(32), .ABITS(4)) bus ();

    regfile_wb_queue #(.DBITS(32), .ABITS(4), .DEPTH(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.we) rf[bus.waddr] <= bus.din;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ld(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.ld_valid = v;
        bus.ld_addr  = a;
        bus.ld_data  = d;
    endtask

    task automatic set_alu(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    initial begin
        // Reset with both pushes held high
        set_ld(1'b1, 4'd1, 32'hDEAD);
        set_alu(1'b1, 4'd2, 32'hBEEF);
        bus.raddr1 = 4'd1;
        bus.raddr2 = 4'd2;
        tick();
        tick();
        check("rst_we", bus.we, 0);
        check("rst_stall", bus.stall, 0);
        set_ld(1'b0, 4'd0, 32'h0);
        set_alu(1'b0, 4'd0, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_we", bus.we, 0);
        check("post_rst_stall", bus.stall, 0);
        check("post_rst_waddr", bus.waddr, 0);
        check("post_rst_din", bus.din, 0);
        check("post_rst_fwd1_hit", bus.fwd1_hit, 0);
        check("post_rst_fwd1_data", bus.fwd1_data, 0);
        check("post_rst_fwd2_hit", bus.fwd2_hit, 0);
        check("post_rst_fwd2_data", bus.fwd2_data, 0);

        // Single LD push, one-cycle latency to the write port
        set_ld(1'b1, 4'd3, 32'h11);
        bus.raddr1 = 4'd3;
        tick();
        set_ld(1'b0, 4'd0, 32'h0);
        check("first_we", bus.we, 1);
        check("first_waddr", bus.waddr, 3);
        check("first_din", bus.din, 32'h11);
        check("first_fwd_hit", bus.fwd1_hit, 1);
        check("first_fwd_data", bus.fwd1_data, 32'h11);
        tick();
        check("first_we_off", bus.we, 0);
        check("first_fwd_off", bus.fwd1_hit, 0);
        check("rf3", rf[3], 32'h11);

        // WAW: same-cycle LD and ALU to r5
        set_ld(1'b1, 4'd5, 32'hAA);
        set_alu(1'b1, 4'd5, 32'hBB);
        bus.raddr1 = 4'd5;
        bus.raddr2 = 4'd5;
        tick();
        set_ld(1'b0, 4'd0, 32'h0);
        set_alu(1'b0, 4'd0, 32'h0);
        check("waw_fwd1_hit", bus.fwd1_hit, 1);
        check("waw_fwd1_data", bus.fwd1_data, 32'hBB);
        check("waw_fwd2_data", bus.fwd2_data, 32'hBB);
        check("waw_w0_addr", bus.waddr, 5);
        check("waw_w0_din", bus.din, 32'hAA);
        tick();
        check("waw_w1_we", bus.we, 1);
        check("waw_w1_din", bus.din, 32'hBB);
        check("waw_fwd_young", bus.fwd1_data, 32'hBB);
        tick();
        check("waw_idle", bus.we, 0);
        check("waw_rf5", rf[5], 32'hBB);

        // Fill with two pushes per cycle; third pair lands on STALL and is dropped
        bus.raddr1 = 4'd6;
        set_ld(1'b1, 4'd1, 32'h101);
        set_alu(1'b1, 4'd2, 32'h102);
        #1;
        check("fill_stall0", bus.stall, 0);
        tick();
        set_ld(1'b1, 4'd3, 32'h103);
        set_alu(1'b1, 4'd4, 32'h104);
        check("fill_stall1", bus.stall, 0);
        check("fill_w0", bus.din, 32'h101);
        tick();
        check("fill_stall_hi", bus.stall, 1);
        check("fill_w1", bus.din, 32'h102);
        set_ld(1'b1, 4'd5, 32'h105);
        set_alu(1'b1, 4'd6, 32'h106);
        tick();
        set_ld(1'b0, 4'd0, 32'h0);
        set_alu(1'b0, 4'd0, 32'h0);
        check("fill_stall_lo", bus.stall, 0);
        check("fill_w2_addr", bus.waddr, 3);
        check("fill_w2", bus.din, 32'h103);
        check("fill_no_fwd6", bus.fwd1_hit, 0);
        tick();
        check("fill_w3", bus.din, 32'h104);
        tick();
        check("fill_idle", bus.we, 0);
        check("fill_rf4", rf[4], 32'h104);
        check("fill_rf5_kept", rf[5], 32'hBB);
        check("fill_rf6_untouched", rf[6], 0);

        // One push, one pop per cycle across pointer wrap
        for (int k = 0; k < 9; k++) begin
            set_ld(1'b1, 4'(k + 1), 32'h200 + k);
            tick();
            check("wrap_we", bus.we, 1);
            check("wrap_waddr", bus.waddr, k + 1);
            check("wrap_din", bus.din, 32'h200 + k);
            check("wrap_stall", bus.stall, 0);
        end
        set_ld(1'b0, 4'd0, 32'h0);
        tick();
        check("wrap_idle", bus.we, 0);
        check("wrap_rf9", rf[9], 32'h208);

        // Reset mid-drain with three entries queued
        set_ld(1'b1, 4'd11, 32'h301);
        set_alu(1'b1, 4'd12, 32'h302);
        tick();
        set_ld(1'b1, 4'd13, 32'h303);
        set_alu(1'b1, 4'd14, 32'h304);
        tick();
        set_ld(1'b0, 4'd0, 32'h0);
        set_alu(1'b0, 4'd0, 32'h0);
        check("mid_stall", bus.stall, 1);
        check("mid_waddr", bus.waddr, 12);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_we", bus.we, 0);
        check("mid_rst_waddr", bus.waddr, 0);
        check("mid_rst_din", bus.din, 0);
        check("mid_rst_stall", bus.stall, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rel_we", bus.we, 0);
        tick();
        check("mid_rel_we2", bus.we, 0);
        check("mid_rf11", rf[11], 32'h301);
        check("mid_rf12", rf[12], 0);
        check("mid_rf13", rf[13], 0);
        check("mid_rf14", rf[14], 0);

        // ALU push to r0
        set_alu(1'b1, 4'd0, 32'h55);
        bus.raddr1 = 4'd0;
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
`ifdef REGFILE_ZERO_R0_EN
        check("r0_we", bus.we, 0);
        check("r0_fwd_hit", bus.fwd1_hit, 0);
        check("r0_fwd_data", bus.fwd1_data, 0);
`else
        check("r0_we", bus.we, 1);
        check("r0_waddr", bus.waddr, 0);
        check("r0_din", bus.din, 32'h55);
        check("r0_fwd_hit", bus.fwd1_hit, 1);
`endif
        tick();
        check("r0_idle", bus.we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
